// File: rtl/register_file_if.sv
// Bus bundle for the RV32I integer register file: two read ports and one writeback port.
// The master drives indices and writeback; the slave (register file) returns operands.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// RV32I integer register file: x0 hardwired to zero, two combinational reads, one clocked write.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h0000_0FFC
) (
  input logic            clk,
  input logic            rst_n,
  register_file_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0_IDX = {ADDR_WIDTH{1'b0}};

  // x0 has no storage; the array starts at index 1.
  logic [DATA_WIDTH-1:0] regs_r [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] read_data1_s;
  logic [DATA_WIDTH-1:0] read_data2_s;
  logic                  write_en_s;

  assign write_en_s = bus.reg_write && (bus.write_reg != X0_IDX);

  // Storage array: async reset to zero with sp preloaded, otherwise clocked writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= (i == 32'sd2) ? SP_RESET : {DATA_WIDTH{1'b0}};
      end
    end else if (write_en_s) begin
      regs_r[bus.write_reg] <= bus.write_data;
    end
  end

  // Read port 1 operand selection.
  always_comb begin
    read_data1_s = {DATA_WIDTH{1'b0}};
    if (bus.read_reg1 == X0_IDX) begin
      read_data1_s = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (rst_n && write_en_s && (bus.read_reg1 == bus.write_reg)) begin
      read_data1_s = bus.write_data;
`endif
    end else begin
      read_data1_s = regs_r[bus.read_reg1];
    end
  end

  // Read port 2 operand selection.
  always_comb begin
    read_data2_s = {DATA_WIDTH{1'b0}};
    if (bus.read_reg2 == X0_IDX) begin
      read_data2_s = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (rst_n && write_en_s && (bus.read_reg2 == bus.write_reg)) begin
      read_data2_s = bus.write_data;
`endif
    end else begin
      read_data2_s = regs_r[bus.read_reg2];
    end
  end

  assign bus.read_data1 = read_data1_s;
  assign bus.read_data2 = read_data2_s;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes predicted read values, a negedge monitor compares.
// The reference model is a plain array updated by the architectural write rules.
module tb_register_file;
  localparam logic [31:0] SP = 32'h0000_0FFC;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  logic clk;
  logic rst_n;
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] model [32];
  exp_t        sb_q [$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP;
  endfunction

  function automatic logic [31:0] predict(input int r);
    if (r == 0) return 32'h0;
    if (BYP && rst_n && bus.reg_write && (int'(bus.write_reg) == r)) return bus.write_data;
    return model[r];
  endfunction

  // Called just after a posedge: apply inputs, predict reads, let one edge pass, update the model.
  task automatic drive(input logic rst, input int rr1, input int rr2, input logic we,
                       input int wr, input logic [31:0] wd, input string name);
    exp_t e;
    rst_n = rst;
    if (!rst) model_reset();
    bus.read_reg1  = 5'(rr1);
    bus.read_reg2  = 5'(rr2);
    bus.reg_write  = we;
    bus.write_reg  = 5'(wr);
    bus.write_data = wd;
    #0;
    e.name = name;
    e.e1 = predict(rr1);
    e.e2 = predict(rr2);
    sb_q.push_back(e);
    @(posedge clk);
    if (rst_n && we && wr != 0) model[wr] = wd;
    #1;
  endtask

  // Monitor: read ports are always presented; compare once per queued prediction.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      n_cmp++;
      if (bus.read_data1 !== cur.e1) begin
        n_fail++;
        $display("FAIL %s rd1: got %h expected %h", cur.name, bus.read_data1, cur.e1);
      end
      n_cmp++;
      if (bus.read_data2 !== cur.e2) begin
        n_fail++;
        $display("FAIL %s rd2: got %h expected %h", cur.name, bus.read_data2, cur.e2);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.read_reg1 = 5'd0; bus.read_reg2 = 5'd0; bus.reg_write = 1'b0;
    bus.write_reg = 5'd0; bus.write_data = 32'h0;
    model_reset();
    @(posedge clk); #1;

    drive(1'b0, 2, 5, 1'b0, 0, 32'h0, "reset_vals");
    drive(1'b0, 5, 6, 1'b1, 5, 32'h1111_2222, "write_in_reset");
    drive(1'b1, 5, 2, 1'b0, 0, 32'h0, "after_release");

    drive(1'b1, 0, 0, 1'b1, 10, 32'd12, "wr_x10");
    drive(1'b1, 10, 11, 1'b1, 11, 32'd12, "wr_x11");
    drive(1'b1, 10, 11, 1'b0, 0, 32'h0, "read_x10_x11");

    drive(1'b1, 0, 10, 1'b1, 0, 32'hFFFF_FFFF, "wr_x0");
    drive(1'b1, 0, 0, 1'b0, 0, 32'h0, "read_x0");

    for (int k = 0; k < 3; k++) drive(1'b1, 7, 7, 1'b0, 7, 32'h1234_5678, "we_off");
    drive(1'b1, 7, 7, 1'b0, 0, 32'h0, "read_x7");

    drive(1'b1, 0, 0, 1'b1, 3, 32'd5, "wr_x3");
    drive(1'b1, 3, 3, 1'b1, 3, 32'd9, "hazard_pre");
    drive(1'b1, 3, 0, 1'b0, 0, 32'h0, "hazard_post");

    drive(1'b1, 0, 0, 1'b1, 5, 32'hDEAD_BEEF, "wr_x5");
    drive(1'b1, 2, 5, 1'b0, 0, 32'h0, "read_x5");
    drive(1'b0, 2, 5, 1'b0, 0, 32'h0, "async_reset");
    drive(1'b1, 5, 2, 1'b0, 0, 32'h0, "release2");

    // Reset asserted on the same edge as a write to x4: the write must be lost.
    bus.reg_write = 1'b1; bus.write_reg = 5'd4; bus.write_data = 32'hA5A5_A5A5;
    bus.read_reg1 = 5'd0; bus.read_reg2 = 5'd0;
    @(posedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    drive(1'b0, 4, 2, 1'b0, 0, 32'h0, "rst_vs_wr_hold");
    drive(1'b1, 4, 4, 1'b0, 0, 32'h0, "rst_vs_wr_post");

    for (int k = 0; k < 300; k++) begin
      int wr;
      wr = $urandom_range(31, 0);
      drive(1'b1,
            ($urandom_range(3, 0) == 0) ? wr : int'($urandom_range(31, 0)),
            $urandom_range(31, 0),
            1'($urandom_range(1, 0)), wr, $urandom(), "random");
    end

    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file for the RV32I core, sitting directly upstream of the ALU.
- Provides the two source operands that drive the ALU's read_data1/read_data2 inputs, and accepts the writeback result.
- 32 registers with x0 hardwired to zero; two asynchronous read ports and one synchronous write port.
- Write-to-read bypass is optional (see Optional Feature).

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH.
- SP_RESET, 32'h0000_0FFC, reset value loaded into x2 (sp); every other register resets to 0.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_reg1  input  ADDR_WIDTH  rs1 index.
- read_reg2  input  ADDR_WIDTH  rs2 index.
- write_reg  input  ADDR_WIDTH  rd index.
- write_data  input  DATA_WIDTH  writeback value.
- reg_write  input  1  write enable, sampled at posedge clk.
- read_data1  output  DATA_WIDTH  contents of read_reg1; feeds ALU operand A.
- read_data2  output  DATA_WIDTH  contents of read_reg2; feeds ALU operand B.

Clock/reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.

Behaviour:
- Reset:
  - rst_n low immediately clears x1 and x3..x31 to 0 and sets x2 to SP_RESET, without waiting for a clock edge.
  - Read outputs follow combinationally during reset: 0, or SP_RESET when the index is 2.
  - Reset dominates a write in the same cycle; that write is lost.
  - Deassertion is synchronised externally; the first write is accepted on the first rising edge after rst_n goes high.
- Write:
  - At posedge clk, when reg_write=1 and write_reg!=0, regs[write_reg] <= write_data. The value is visible on the read ports after that edge (0-cycle read latency, 1-cycle write latency).
  - Writes to x0 are silently discarded; x0 is not implemented as storage.
  - reg_write=0 leaves all registers unchanged regardless of write_reg/write_data.
- Read:
  - Purely combinational: read_dataN = (read_regN==0) ? 0 : regs[read_regN].
  - No clock or enable on the read path.
  - Both ports may address the same register, returning identical values.
- Same-cycle read and write of the same nonzero index, without bypass: the read returns the OLD value until the edge.
- Width rules: indices are unsigned; all 2**ADDR_WIDTH indices are valid, so no out-of-range case exists. Data is stored verbatim with no sign handling.
- No internal state machine beyond the storage array; no stall or handshake. Upstream control guarantees at most one write per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN = write_data combinationally in the same cycle. This gives write-before-read semantics for a pipelined writeback stage. x0 reads remain 0 even when write_reg==0. The bypass is gated off while rst_n is low.
- Undefined: no bypass path; behaviour is exactly as under Behaviour (read-old-value).

Test Plan:
- Reset: hold rst_n=0, read_reg1=2, read_reg2=5 -> read_data1=32'h0000_0FFC, read_data2=0. Asserting rst_n mid-simulation after writing x5=32'hDEAD_BEEF returns read_data2=0 with no clock edge.
- Basic write/read: write x10=32'd12 and x11=32'd12 on consecutive edges; read_reg1=10, read_reg2=11 -> both 32'd12, ready to drive an ALU add with result 24 and zero_bit=0.
- x0 protection: reg_write=1, write_reg=0, write_data=32'hFFFF_FFFF, one edge; read_reg1=0 -> 0.
- Write disable: reg_write=0, write_reg=7, write_data=32'h1234_5678, three edges -> read of x7 still 0 after reset.
- Same-cycle hazard: x3=32'd5, then the same cycle drives reg_write=1, write_reg=3, write_data=32'd9, read_reg1=3.
  - Without REGFILE_BYPASS_EN: 5 before the edge, 9 after.
  - With REGFILE_BYPASS_EN: 9 before the edge.
- Reset vs write: assert rst_n=0 coincident with a posedge write x4=32'hA5A5_A5A5 -> x4 reads 0 after release.
